// File: rtl/kitchen_suppression_actuator_ctrl_if.sv
// rtl/kitchen_suppression_actuator_ctrl_if.sv - detector/valve/fan signal bundle for the suppression actuator controller
// Purpose: groups the detector, limit-switch, operator and actuator signals.
// Ports (slave = controller view):
//   sprinkler_req, vent_req, valve_open_ack, manual_reset : asynchronous inputs
//   valve_cmd, fan_cmd, alarm, fault                      : registered outputs
//   state[2:0]                                            : sprinkler FSM state code
interface kitchen_suppression_actuator_ctrl_if;
    logic       sprinkler_req;
    logic       vent_req;
    logic       valve_open_ack;
    logic       manual_reset;
    logic       valve_cmd;
    logic       fan_cmd;
    logic       alarm;
    logic       fault;
    logic [2:0] state;

    modport master (
        output sprinkler_req, vent_req, valve_open_ack, manual_reset,
        input  valve_cmd, fan_cmd, alarm, fault, state
    );

    modport slave (
        input  sprinkler_req, vent_req, valve_open_ack, manual_reset,
        output valve_cmd, fan_cmd, alarm, fault, state
    );
endinterface

// File: rtl/kitchen_suppression_actuator_ctrl.sv
// rtl/kitchen_suppression_actuator_ctrl.sv - kitchen sprinkler valve FSM with ventilation fan run-on
// Purpose: drives the sprinkler valve from detector demand with limit-switch
// supervision, and the ventilation fan with a run-on hold after demand drops.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   io    : slave modport of kitchen_suppression_actuator_ctrl_if
module kitchen_suppression_actuator_ctrl #(
    parameter int MIN_SPRAY   = 16,
    parameter int ACK_TIMEOUT = 8,
    parameter int VENT_HOLD   = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    kitchen_suppression_actuator_ctrl_if.slave io
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_OPENING  = 3'd1,
        S_SPRAYING = 3'd2,
        S_CLOSING  = 3'd3,
        S_FAULT    = 3'd4
    } state_t;

    // The timer holds the number of completed edges in the current state, so
    // the cycle now in progress is timer+1; thresholds compare against N-1.
    localparam logic [15:0] LP_SPRAY_LAST = 16'(MIN_SPRAY - 1);
    localparam logic [15:0] LP_ACK_LAST   = 16'(ACK_TIMEOUT - 1);
    localparam logic [15:0] LP_VENT_HOLD  = 16'(VENT_HOLD);

    // Synchronizers: bit 0 req, 1 vent, 2 ack, 3 manual reset
    logic [3:0]  r_sync1;
    logic [3:0]  r_sync2;
    logic [3:0]  w_async_in;
    logic        w_req_s;
    logic        w_vent_s;
    logic        w_ack_s;
    logic        w_mr_s;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_timer;
    logic [15:0] r_hold;
    logic [15:0] w_hold_nxt;
    logic        w_fan_src;
    logic        r_valve_cmd;
    logic        r_fan_cmd;
    logic        r_alarm;
    logic        r_fault;

    assign w_async_in = {io.manual_reset, io.valve_open_ack, io.vent_req, io.sprinkler_req};
    assign w_req_s    = r_sync2[0];
    assign w_vent_s   = r_sync2[1];
    assign w_ack_s    = r_sync2[2];
    assign w_mr_s     = r_sync2[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 4'b0;
            r_sync2 <= 4'b0;
        end else begin
            r_sync1 <= w_async_in;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req_s) w_state_nxt = S_OPENING;
            end
            S_OPENING: begin
                if (w_ack_s)                      w_state_nxt = S_SPRAYING;
                else if (r_timer >= LP_ACK_LAST)  w_state_nxt = S_FAULT;
            end
            S_SPRAYING: begin
                // Loss of the open indication outranks the normal close.
                if (!w_ack_s)                                   w_state_nxt = S_FAULT;
                else if (r_timer >= LP_SPRAY_LAST && !w_req_s)  w_state_nxt = S_CLOSING;
            end
            S_CLOSING: begin
                if (w_req_s)                      w_state_nxt = S_OPENING;
                else if (!w_ack_s)                w_state_nxt = S_IDLE;
                else if (r_timer >= LP_ACK_LAST)  w_state_nxt = S_FAULT;
            end
            S_FAULT: begin
                if (w_mr_s && !w_req_s) w_state_nxt = S_CLOSING;
            end
            default: w_state_nxt = S_FAULT;
        endcase
    end

    // Fan sources are judged on the state being entered so fan and alarm
    // rise together; the hold counter only matters once sources go quiet.
    always_comb begin
        w_fan_src  = w_vent_s || (w_state_nxt != S_IDLE);
        w_hold_nxt = r_hold;
        if (w_fan_src)          w_hold_nxt = LP_VENT_HOLD;
        else if (r_hold != 0)   w_hold_nxt = r_hold - 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_timer     <= 16'd0;
            r_hold      <= 16'd0;
            r_valve_cmd <= 1'b0;
            r_fan_cmd   <= 1'b0;
            r_alarm     <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state)  r_timer <= 16'd0;
            else if (r_timer != 16'hFFFF) r_timer <= r_timer + 16'd1;
            r_hold      <= w_hold_nxt;
            r_valve_cmd <= (w_state_nxt == S_OPENING) || (w_state_nxt == S_SPRAYING) ||
                           (w_state_nxt == S_FAULT);
            r_fan_cmd   <= w_fan_src || (w_hold_nxt != 16'd0);
            r_alarm     <= (w_state_nxt != S_IDLE);
            r_fault     <= (w_state_nxt == S_FAULT);
        end
    end

    assign io.valve_cmd = r_valve_cmd;
    assign io.fan_cmd   = r_fan_cmd;
    assign io.alarm     = r_alarm;
    assign io.fault     = r_fault;
    assign io.state     = r_state;
endmodule

// File: tb/tb_kitchen_suppression_actuator_ctrl.sv
// tb/tb_kitchen_suppression_actuator_ctrl.sv - randomized self-checking bench for kitchen_suppression_actuator_ctrl
module tb_kitchen_suppression_actuator_ctrl;
    localparam int MIN_SPRAY   = 16;
    localparam int ACK_TIMEOUT = 8;
    localparam int VENT_HOLD   = 32;

    logic clk;
    logic rst_n;
    kitchen_suppression_actuator_ctrl_if bus ();

    kitchen_suppression_actuator_ctrl #(
        .MIN_SPRAY   (MIN_SPRAY),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .VENT_HOLD   (VENT_HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;
    int cyc;

    // Reference model: inputs seen by the controller are those present two
    // edges earlier; spent = cycles completed in the current state.
    int   m_state;
    int   m_spent;
    int   m_edge;
    int   m_last_src;
    logic [3:0] m_h1;
    logic [3:0] m_h2;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state    = 0;
        m_spent    = 0;
        m_edge     = 0;
        m_last_src = -100000;
        m_h1       = 4'b0;
        m_h2       = 4'b0;
    endtask

    task automatic model_step();
        logic req, vent, ack, mr;
        int   nxt;
        req  = m_h2[0];
        vent = m_h2[1];
        ack  = m_h2[2];
        mr   = m_h2[3];
        m_h2 = m_h1;
        m_h1 = {bus.manual_reset, bus.valve_open_ack, bus.vent_req, bus.sprinkler_req};
        m_spent++;
        nxt = m_state;
        if (m_state == 0) begin
            if (req) nxt = 1;
        end else if (m_state == 1) begin
            if (ack) nxt = 2;
            else if (m_spent >= ACK_TIMEOUT) nxt = 4;
        end else if (m_state == 2) begin
            if (!ack) nxt = 4;
            else if (m_spent >= MIN_SPRAY && !req) nxt = 3;
        end else if (m_state == 3) begin
            if (req) nxt = 1;
            else if (!ack) nxt = 0;
            else if (m_spent >= ACK_TIMEOUT) nxt = 4;
        end else begin
            if (mr && !req) nxt = 3;
        end
        if (nxt != m_state) m_spent = 0;
        m_state = nxt;
        if (vent || m_state != 0) m_last_src = m_edge;
        m_edge++;
    endtask

    task automatic compare_all(input string where);
        logic e_fan;
        e_fan = ((m_edge - 1 - m_last_src) < VENT_HOLD);
        check_val({where, ".state"}, 16'(bus.state), 16'(m_state));
        check_val({where, ".valve"}, 16'(bus.valve_cmd),
                  16'(m_state == 1 || m_state == 2 || m_state == 4));
        check_val({where, ".alarm"}, 16'(bus.alarm), 16'(m_state != 0));
        check_val({where, ".fault"}, 16'(bus.fault), 16'(m_state == 4));
        check_val({where, ".fan"},   16'(bus.fan_cmd), 16'(e_fan));
    endtask

    task automatic check_all_zero(input string where);
        check_val({where, ".state"}, 16'(bus.state), 16'd0);
        check_val({where, ".valve"}, 16'(bus.valve_cmd), 16'd0);
        check_val({where, ".alarm"}, 16'(bus.alarm), 16'd0);
        check_val({where, ".fault"}, 16'(bus.fault), 16'd0);
        check_val({where, ".fan"},   16'(bus.fan_cmd), 16'd0);
    endtask

    logic [1:0] ack_pipe;
    int         ack_mode;   // 0 follows valve after 2 cycles, 1 stuck closed, 2 stuck open
    int         n_nonidle_resets;

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        n_nonidle_resets = 0;
        rst_n = 1'b0;
        bus.sprinkler_req  = 1'b0;
        bus.vent_req       = 1'b0;
        bus.valve_open_ack = 1'b0;
        bus.manual_reset   = 1'b0;
        ack_pipe = 2'b0;
        ack_mode = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        for (cyc = 0; cyc < 6000; cyc++) begin
            // Asynchronous reset mid-run, preferably while the valve FSM is busy.
            if ((cyc % 1500) == 1499 || (cyc > 300 && m_state == 2 && n_nonidle_resets < 3 &&
                                         $urandom_range(0, 99) == 0)) begin
                if (m_state != 0) n_nonidle_resets++;
                rst_n = 1'b0;
                #1;
                check_all_zero("async_rst");
                model_reset();
                ack_pipe = 2'b0;
                repeat (3) @(negedge clk);
                check_all_zero("held_rst");
                rst_n = 1'b1;
            end

            if ($urandom_range(0, 24) == 0) bus.sprinkler_req = ~bus.sprinkler_req;
            if ($urandom_range(0, 29) == 0) bus.vent_req = ~bus.vent_req;
            if ($urandom_range(0, 79) == 0) ack_mode = ($urandom_range(0, 9) < 7) ? 0 :
                                                       int'($urandom_range(1, 2));
            bus.manual_reset = ($urandom_range(0, 11) == 0);
            ack_pipe = {ack_pipe[0], bus.valve_cmd};
            if (ack_mode == 0)      bus.valve_open_ack = ack_pipe[1];
            else if (ack_mode == 1) bus.valve_open_ack = 1'b0;
            else                    bus.valve_open_ack = 1'b1;

            @(posedge clk);
            model_step();
            @(negedge clk);
            compare_all("run");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/kitchen_suppression_actuator_ctrl.md
KITCHEN_SUPPRESSION_ACTUATOR_CTRL -- requirements
Module: kitchen_suppression_actuator_ctrl

Interface
REQ-001 Parameter MIN_SPRAY, default 16: minimum clk cycles spent in SPRAYING.
REQ-002 Parameter ACK_TIMEOUT, default 8: maximum clk cycles to wait for a valve limit-switch response.
REQ-003 Parameter VENT_HOLD, default 32: fan run-on clk cycles after all ventilation sources drop.
REQ-004 clk  input  1  single system clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 sprinkler_req  input  1  asynchronous sprinkler demand from the kitchen fire/smoke detector.
REQ-007 vent_req  input  1  asynchronous ventilation demand from the kitchen fire/smoke detector.
REQ-008 valve_open_ack  input  1  asynchronous valve limit switch; 1 = valve physically open.
REQ-009 manual_reset  input  1  asynchronous operator push-button; clears FAULT.
REQ-010 valve_cmd  output  1  sprinkler valve drive; 1 = open.
REQ-011 fan_cmd  output  1  ventilation fan drive; 1 = run.
REQ-012 alarm  output  1  1 whenever the sprinkler FSM is not IDLE.
REQ-013 fault  output  1  1 only in FAULT.
REQ-014 state  output  3  current sprinkler FSM state code.

Function
REQ-015 Every asynchronous input SHALL pass through a two-flop synchronizer; the FSM and fan logic use only synchronized values.
REQ-016 All outputs SHALL be registered.
REQ-017 Latency: input change before edge N is visible to the FSM after edge N+1; registered outputs change at edge N+2.
REQ-018 State codes: IDLE=0, OPENING=1, SPRAYING=2, CLOSING=3, FAULT=4; codes 5-7 SHALL return to FAULT on the next edge.
REQ-019 A 16-bit state timer SHALL clear on every state entry and increment each cycle, saturating at all-ones.
REQ-020 IDLE: valve_cmd=0; synced sprinkler_req=1 -> OPENING.
REQ-021 OPENING: valve_cmd=1; synced ack=1 -> SPRAYING; timer reaching ACK_TIMEOUT with ack=0 -> FAULT.
REQ-022 SPRAYING: valve_cmd=1.
- ack=0 -> FAULT, with priority over all other SPRAYING exits.
- Otherwise timer>=MIN_SPRAY and synced sprinkler_req=0 -> CLOSING.
- sprinkler_req dropping earlier SHALL NOT shorten the spray.
REQ-023 CLOSING: valve_cmd=0.
- Synced sprinkler_req=1 -> OPENING, with priority.
- Otherwise ack=0 -> IDLE.
- Otherwise timer reaching ACK_TIMEOUT with ack=1 -> FAULT.
REQ-024 FAULT (fail-safe): valve_cmd=1, fan_cmd=1, fault=1.
- Synced manual_reset=1 and synced sprinkler_req=0 -> CLOSING.
- manual_reset while sprinkler_req=1 SHALL be ignored.
REQ-025 Fan hold counter: loads VENT_HOLD while any fan source is active; decrements each cycle while all sources are inactive; stops at 0.
- Fan sources: synced vent_req=1, or FSM not IDLE.
REQ-026 fan_cmd SHALL be 1 while a fan source is active or the hold counter is nonzero, else 0.
- A source re-asserting during run-on SHALL reload the counter.
REQ-027 Sprinkler FSM and fan logic SHALL be independent except through REQ-025 and REQ-024.

Reset
REQ-028 rst_n=0 SHALL immediately and asynchronously force: state=IDLE, valve_cmd=0, fan_cmd=0, alarm=0, fault=0, timer=0, hold counter=0, synchronizer flops=0.
REQ-029 Reset mid-operation, including during FAULT, SHALL discard all state with no further valve drive.
REQ-030 After rst_n rises, operation SHALL resume on the first rising clk edge.

Verification
REQ-031 vent_req pulse 5 cycles, sprinkler_req=0 -> fan_cmd high 2 edges after assert; low VENT_HOLD(32) cycles after synced drop; valve_cmd stays 0.
REQ-032 sprinkler_req=1 for 3 cycles, ack follows valve_cmd after 2 cycles -> sequence IDLE, OPENING, SPRAYING for 16 cycles, CLOSING, IDLE; alarm=1 throughout non-IDLE; fan run-on 32 cycles after IDLE.
REQ-033 sprinkler_req=1, ack held 0 -> FAULT 8 cycles after OPENING entry with valve_cmd=1, fault=1.
- manual_reset with req=1 is ignored.
- manual_reset with req=0 -> CLOSING.
- ack=0 -> IDLE.
REQ-034 ack drops mid-SPRAYING -> FAULT next edge after the synced drop.
- sprinkler_req re-asserted during CLOSING -> OPENING without passing through IDLE.
REQ-035 rst_n pulsed low during SPRAYING -> all outputs 0 immediately; no activity until sprinkler_req is re-sampled high.
